// File: rtl/abro_multi_fsm.sv
// abro_multi_fsm: parametrised ABRO controller. Collects each of N_EVENTS
// inputs at least once, in any order, then fires o. Optional one-cycle pulse
// output, optional collection timeout, and a wrapping count of completed rounds.
module abro_multi_fsm #(
  parameter int N_EVENTS  = 3,
  parameter int PULSE_OUT = 0,
  parameter int TIMEOUT   = 0,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_EVENTS-1:0] ev,
  input  logic                r,
  output logic                o,
  output logic [1:0]          state,
  output logic [N_EVENTS-1:0] seen,
  output logic                timeout,
  output logic [CNT_W-1:0]    fire_count
);

  // Timer only needs to count up to TIMEOUT; keep at least one bit when disabled.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT);
  localparam logic [N_EVENTS-1:0] ALL      = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FIRE    = 2'd2,
    S_HOLD    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_EVENTS-1:0] seen_q, seen_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                o_q, o_d;
  logic                timeout_q, timeout_d;
  logic [N_EVENTS-1:0] nxt;
  logic [TMR_W-1:0]    timer_inc;

  assign nxt       = seen_q | ev;
  assign timer_inc = timer_q + 1'b1;

  // Next-state logic: restart > completion > timeout > accumulation.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    seen_d    = seen_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    if (r) begin
      state_d = S_IDLE;
      seen_d  = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (nxt == ALL) begin
            state_d = S_FIRE;
            seen_d  = ALL;
            cnt_d   = cnt_q + 1'b1;
          end else if (ev != '0) begin
            state_d = S_COLLECT;
            seen_d  = ev;
            timer_d = '0;
          end
        end
        S_COLLECT: begin
          seen_d = nxt;
          if (nxt == ALL) begin
            // Completion wins over a timeout expiring on the same edge.
            state_d = S_FIRE;
            seen_d  = ALL;
            cnt_d   = cnt_q + 1'b1;
          end else if (TIMEOUT != 0) begin
            timer_d = timer_inc;
            if (timer_inc == TMR_LAST) begin
              state_d   = S_IDLE;
              seen_d    = '0;
              timer_d   = '0;
              timeout_d = 1'b1;
            end
          end
        end
        S_FIRE: begin
          if (PULSE_OUT != 0) state_d = S_HOLD;
        end
        S_HOLD: begin
          // Round finished; ev ignored until restart.
        end
        default: begin
          state_d = S_IDLE;
          seen_d  = '0;
          timer_d = '0;
        end
      endcase
    end

    o_d = (state_d == S_FIRE);
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      seen_q    <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      o_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q   <= state_d;
      seen_q    <= seen_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      o_q       <= o_d;
      timeout_q <= timeout_d;
    end
  end

  assign o          = o_q;
  assign state      = state_q;
  assign seen       = seen_q;
  assign timeout    = timeout_q;
  assign fire_count = cnt_q;

endmodule
